// File: rtl/test_register_bank_if.sv
// ---------------------------------------------------------------------------
// test_register_bank_if
// Bus bundle for the test register bank.
//   cs       : chip select, one access per assertion
//   write    : 1 = write, 0 = read
//   addr     : register index; values >= 2**ADDR_W select the auxiliary window
//   byte_en  : per-byte write strobes
//   data_in  : write data
//   data_out : registered read data
//   ack      : one-cycle access-complete pulse
// Modports: master drives the request side, slave drives data_out/ack.
// ---------------------------------------------------------------------------
interface test_register_bank_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 2
);
    logic                 cs;
    logic                 write;
    logic [ADDR_W:0]      addr;
    logic [WIDTH/8-1:0]   byte_en;
    logic [WIDTH-1:0]     data_in;
    logic [WIDTH-1:0]     data_out;
    logic                 ack;

    modport master (
        output cs, write, addr, byte_en, data_in,
        input  data_out, ack
    );

    modport slave (
        input  cs, write, addr, byte_en, data_in,
        output data_out, ack
    );
endinterface

// File: rtl/test_register_bank.sv
// ---------------------------------------------------------------------------
// test_register_bank
// Small byte-writable register bank with a cs/ack handshake.
//   clock : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : test_register_bank_if.slave (cs, write, addr, byte_en, data_in,
//           data_out, ack)
// Each cs assertion performs exactly one access: IDLE accepts, ACK pulses
// ack for one cycle, RELEASE waits for cs to drop.
// Optional feature: define TEST_REGISTER_BANK_WRCOUNT_EN to add a WIDTH-bit
// counter of effective writes, readable through the auxiliary window.
// Without it the auxiliary window reads as zero.
// ---------------------------------------------------------------------------
module test_register_bank #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 2
) (
    input logic                  clock,
    input logic                  reset,
    test_register_bank_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned NB    = WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        RELEASE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   regs_q [DEPTH];
    logic [WIDTH-1:0]   regs_d [DEPTH];
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   aux_val;
    logic               accept;
    logic               in_range;
    logic [ADDR_W-1:0]  idx;

    // Request inputs only matter on the accepting edge.
    assign accept   = (state_q == IDLE) && bus.cs;
    assign in_range = ~bus.addr[ADDR_W];
    assign idx      = bus.addr[ADDR_W-1:0];

`ifdef TEST_REGISTER_BANK_WRCOUNT_EN
    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (accept && bus.write && in_range && (|bus.byte_en))
            cnt_d = cnt_q + WIDTH'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // Pre-edge count: the read captures the value before this edge's update.
    assign aux_val = cnt_q;
`else
    assign aux_val = '0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.cs) state_d = ACK;
            ACK:     state_d = RELEASE;
            RELEASE: if (!bus.cs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        if (accept && bus.write && in_range) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (bus.byte_en[b])
                    regs_d[idx][8*b +: 8] = bus.data_in[8*b +: 8];
            end
        end
    end

    // data_out only moves on accepted reads; writes never touch it.
    always_comb begin
        data_d = data_q;
        if (accept && !bus.write)
            data_d = in_range ? regs_q[idx] : aux_val;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++)
                regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            regs_q  <= regs_d;
        end
    end

    assign bus.data_out = data_q;
    assign bus.ack      = (state_q == ACK);
endmodule

// File: tb/tb_test_register_bank.sv
module tb_test_register_bank;
    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    test_register_bank_if #(.WIDTH(32), .ADDR_W(2)) bus ();

    test_register_bank #(.WIDTH(32), .ADDR_W(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    // Reference model state
    logic [31:0] m_regs [4];
    logic [31:0] m_last;
    logic [31:0] m_cnt;
    logic [31:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        m_last = '0;
        m_cnt  = '0;
    endtask

    // Applies one accepted access to the model and queues the data_out value
    // expected while ack is high.
    task automatic model_access(input logic w, input logic [2:0] a,
                                input logic [3:0] be, input logic [31:0] d);
        if (!w) begin
            if (a < 3'd4) m_last = m_regs[a[1:0]];
`ifdef TEST_REGISTER_BANK_WRCOUNT_EN
            else          m_last = m_cnt;
`else
            else          m_last = 32'h0;
`endif
        end else if (a < 3'd4) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) m_regs[a[1:0]][8*b +: 8] = d[8*b +: 8];
            if (be != 4'b0) m_cnt = m_cnt + 32'd1;
        end
        exp_q.push_back(m_last);
    endtask

    // Monitor: every ack pulse consumes one expectation.
    always @(negedge clock) begin
        if (bus.ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("data_out_at_ack", bus.data_out, e);
            end
        end
    end

    task automatic access(input logic w, input logic [2:0] a, input logic [3:0] be,
                          input logic [31:0] d, input int hold);
        @(negedge clock);
        bus.cs = 1'b1; bus.write = w; bus.addr = a; bus.byte_en = be; bus.data_in = d;
        model_access(w, a, be, d);
        @(posedge clock);
        #1 check("ack_latency", {31'b0, bus.ack}, 32'd1);
        // Scramble the ignored inputs while cs stays high.
        for (int i = 1; i < hold; i++) begin
            @(negedge clock);
            bus.write   = ~w;
            bus.addr    = 3'($urandom_range(0, 7));
            bus.byte_en = 4'hF;
            bus.data_in = $urandom;
            @(posedge clock);
        end
        @(negedge clock);
        bus.cs = 1'b0;
        repeat (2) @(posedge clock);
    endtask

    initial begin
        bus.cs = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.byte_en = '0; bus.data_in = '0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check("reset_ack", {31'b0, bus.ack}, 32'd0);
        check("reset_data_out", bus.data_out, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int a = 0; a < 4; a++) access(1'b0, 3'(a), 4'h0, 32'h0, 1);

        access(1'b1, 3'd1, 4'hF, 32'hDEADBEEF, 1);
        access(1'b1, 3'd1, 4'h3, 32'h00001234, 1);
        access(1'b0, 3'd1, 4'h0, 32'h0, 1);            // -> DEAD1234

        access(1'b1, 3'd2, 4'hF, 32'hAAAA5555, 1);
        access(1'b0, 3'd2, 4'h0, 32'h0, 1);            // -> AAAA5555
        access(1'b1, 3'd2, 4'hF, 32'h11111111, 1);     // data_out stays AAAA5555
        #1 check("hold_after_write", bus.data_out, 32'hAAAA5555);
        access(1'b0, 3'd2, 4'h0, 32'h0, 1);            // -> 11111111

        access(1'b1, 3'd3, 4'hF, 32'h12345678, 6);     // long cs: one ack, one update
        access(1'b0, 3'd3, 4'h0, 32'h0, 1);

        access(1'b1, 3'd0, 4'h0, 32'hFFFFFFFF, 1);     // no byte enables
        access(1'b1, 3'd5, 4'hF, 32'h87654321, 1);     // aux window write
        access(1'b0, 3'd0, 4'h0, 32'h0, 1);            // -> 0
        access(1'b0, 3'd4, 4'h0, 32'h0, 1);            // count 5 or 0

        // Reset during the ACK cycle of a write to reg0
        @(negedge clock);
        bus.cs = 1'b1; bus.write = 1'b1; bus.addr = 3'd0; bus.byte_en = 4'hF; bus.data_in = 32'hCAFEF00D;
        model_access(1'b1, 3'd0, 4'hF, 32'hCAFEF00D);
        @(posedge clock);
        #1 check("ack_latency", {31'b0, bus.ack}, 32'd1);
        @(negedge clock);
        reset = 1'b1; bus.cs = 1'b0;
        @(posedge clock);
        #1;
        check("abort_ack", {31'b0, bus.ack}, 32'd0);
        check("abort_data_out", bus.data_out, 32'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        access(1'b0, 3'd0, 4'h0, 32'h0, 1);            // reg0 cleared

        access(1'b1, 3'd0, 4'hF, 32'h00000010, 1);
        access(1'b1, 3'd1, 4'hF, 32'h00000020, 1);
        access(1'b1, 3'd2, 4'hF, 32'h00000030, 1);
        access(1'b1, 3'd3, 4'h0, 32'h00000040, 1);
        access(1'b0, 3'd4, 4'h0, 32'h0, 1);            // 3 or 0
        access(1'b0, 3'd7, 4'h0, 32'h0, 1);

        // cs held through reset: accepted as new access once reset drops
        @(negedge clock);
        reset = 1'b1; bus.cs = 1'b1; bus.write = 1'b0; bus.addr = 3'd1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        model_access(1'b0, 3'd1, 4'h0, 32'h0);
        @(posedge clock);
        #1 check("ack_after_reset_cs_high", {31'b0, bus.ack}, 32'd1);
        @(negedge clock);
        bus.cs = 1'b0;
        repeat (2) @(posedge clock);

        repeat (4) @(posedge clock);
        #1 check("all_acks_seen", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
